// File: rtl/hub75_scanout.sv
// hub75_scanout: 1/64-scan HUB75 BCM driver; reads {half,row,col} from framebuffer (raddr/re/rdata), drives r1..b2, row_a, sclk, lat, oe_n, frame_done
module hub75_scanout #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 6,
  parameter int PLANES   = 6,
  parameter int BASE_ON  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic [ROW_BITS+COL_BITS:0] raddr,
  output logic                       re,
  input  logic [19:0]                rdata,
  output logic                       r1,
  output logic                       g1,
  output logic                       b1,
  output logic                       r2,
  output logic                       g2,
  output logic                       b2,
  output logic [ROW_BITS-1:0]        row_a,
  output logic                       sclk,
  output logic                       lat,
  output logic                       oe_n,
  output logic                       frame_done
);
  localparam int PW = $clog2(PLANES);
  localparam int DW = $clog2((BASE_ON << (PLANES - 1)) + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;
  state_t state, nstate;
  logic [1:0] ph;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic [PW-1:0] plane;
  logic bcnt;
  logic [DW-1:0] dcnt, dlen;
  logic [17:0] top;
  logic [5:0] hold, cnew, rt, gt, bt, rb, gb, bb;
  logic col_end, disp_end, frame_end, unused_rdata;
  assign unused_rdata = ^rdata[19:18];
  assign dlen = DW'(BASE_ON) << plane;
  assign col_end = ph == 2'd3 && &col;
  assign disp_end = dcnt == dlen - DW'(1);
  assign frame_end = state == DISPLAY && disp_end && plane == '0 && &row;
  assign rt = top[17:12] >> plane;
  assign gt = top[11:6] >> plane;
  assign bt = top[5:0] >> plane;
  assign rb = rdata[17:12] >> plane;
  assign gb = rdata[11:6] >> plane;
  assign bb = rdata[5:0] >> plane;
  assign cnew = {rt[0], gt[0], bt[0], rb[0], gb[0], bb[0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  // Colour goes live in ph2 straight from the bottom word so it is settled a full cycle before sclk rises in ph3
  always_comb begin
    nstate = state;
    raddr = '0;
    re = 1'b0;
    sclk = 1'b0;
    lat = state == LATCH;
    oe_n = state != DISPLAY;
    frame_done = frame_end;
    {r1, g1, b1, r2, g2, b2} = (state == SHIFT && ph == 2'd2) ? cnew : hold;
    case (state)
      IDLE:    nstate = enable ? SHIFT : IDLE;
      SHIFT: begin
        raddr = {ph[0], row, col};
        re = !ph[1];
        sclk = ph == 2'd3;
        nstate = col_end ? BLANK : SHIFT;
      end
      BLANK:   nstate = bcnt ? LATCH : BLANK;
      LATCH:   nstate = DISPLAY;
      DISPLAY: nstate = !disp_end ? DISPLAY : (!frame_end || enable) ? SHIFT : IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph <= '0;
      col <= '0;
      row <= '0;
      plane <= '0;
      bcnt <= 1'b0;
      dcnt <= '0;
      top <= '0;
      hold <= '0;
      row_a <= '0;
    end else begin
      case (state)
        IDLE: plane <= PW'(PLANES - 1);
        SHIFT: begin
          ph <= ph + 2'd1;
          col <= ph == 2'd3 ? col + COL_BITS'(1) : col;
          if (ph == 2'd1) top <= rdata[17:0];
          if (ph == 2'd2) hold <= cnew;
          if (col_end) row_a <= row;
        end
        BLANK: bcnt <= !bcnt;
        DISPLAY: begin
          dcnt <= disp_end ? '0 : dcnt + DW'(1);
          if (disp_end) begin
            plane <= plane != '0 ? plane - PW'(1) : PW'(PLANES - 1);
            if (plane == '0) row <= row + ROW_BITS'(1);
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_hub75_scanout.sv
// tb_hub75_scanout: randomized framebuffer against a scan-order reference model for hub75_scanout
module tb_hub75_scanout;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  always #5 clk = ~clk;
  logic [5:0] raddr;
  logic re, r1, g1, b1, r2, g2, b2, sclk, lat, oe_n, frame_done;
  logic [19:0] rdata = '0;
  logic [1:0] row_a;
  logic [13:0] raddr0;
  logic re0, r10, g10, b10, r20, g20, b20, sclk0, lat0, oe_n0, frame_done0;
  logic [19:0] rdata0 = '0;
  logic [5:0] row_a0;
  logic [19:0] mem [64];
  int errors = 0, checks = 0, cyc = 0, nsclk = 0, nlat = 0, nfd = 0, nre = 0, fd_cyc = 0, period = 0;

  hub75_scanout #(.COL_BITS(3), .ROW_BITS(2), .PLANES(6), .BASE_ON(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .raddr(raddr), .re(re), .rdata(rdata),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2), .row_a(row_a),
    .sclk(sclk), .lat(lat), .oe_n(oe_n), .frame_done(frame_done));

  hub75_scanout u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .raddr(raddr0), .re(re0), .rdata(rdata0),
    .r1(r10), .g1(g10), .b1(b10), .r2(r20), .g2(g20), .b2(b20), .row_a(row_a0),
    .sclk(sclk0), .lat(lat0), .oe_n(oe_n0), .frame_done(frame_done0));

  always @(posedge clk) rdata <= mem[raddr];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sclk) nsclk++;
    if (lat) nlat++;
    if (re) nre++;
    if (frame_done) begin
      nfd++;
      period = cyc - fd_cyc;
      fd_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_col(input int row, input int col, input int plane);
    logic [19:0] t, b;
    t = mem[6'(row * 8 + col)] >> plane;
    b = mem[6'(32 + row * 8 + col)] >> plane;
    return {t[12], t[6], t[0], b[12], b[6], b[0]};
  endfunction

  task automatic start_check(input bit both);
    @(negedge clk);
    chk("first_re", 32'(re), 1);
    chk("addr_top", 32'(raddr), 0);
    if (both) chk("addr_top_default", 32'(raddr0), 0);
    @(negedge clk);
    chk("addr_bot", 32'(raddr), 32'h20);
    if (both) chk("addr_bot_default", 32'(raddr0), 32'h2000);
  endtask

  task automatic do_plane(input int row, input int plane);
    int s0, l0, n;
    logic [5:0] e;
    s0 = nsclk;
    l0 = nlat;
    for (int c = 0; c < 8; c++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!sclk && n < 40);
      chk("sclk_seen", 32'(sclk), 1);
      e = exp_col(row, c, plane);
      chk("colour", 32'({r1, g1, b1, r2, g2, b2}), 32'(e));
      @(negedge clk);
      chk("colour_hold", 32'({r1, g1, b1, r2, g2, b2}), 32'(e));
    end
    n = 0;
    while (!lat && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat_seen", 32'(lat), 1);
    chk("lat_oe_n", 32'(oe_n), 1);
    chk("row_a", 32'(row_a), 32'(row));
    chk("sclk_count", 32'(nsclk - s0), 8);
    @(negedge clk);
    n = 0;
    while (!oe_n && n < 600) begin
      n++;
      @(negedge clk);
    end
    chk("on_time", 32'(n), 32'(8 << plane));
    chk("lat_count", 32'(nlat - l0), 1);
    chk("row_a_hold", 32'(row_a), 32'(row));
  endtask

  initial begin
    int n, r0;
    for (int i = 0; i < 64; i++) mem[i] = 20'($urandom);
    mem[29] = 20'h3F000;
    mem[61] = 20'h00000;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({raddr, re, r1, g1, b1, r2, g2, b2, row_a, sclk, lat, frame_done}), 0);
    chk("reset_oe_n", 32'(oe_n), 1);
    chk("reset_outs_default", 32'({raddr0, re0, r10, g10, b10, r20, g20, b20, row_a0, sclk0, lat0, frame_done0}), 0);
    chk("reset_oe_n_default", 32'(oe_n0), 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_re", 32'(nre), 0);
    chk("idle_oe_n", 32'(oe_n), 1);
    enable = 1'b1;
    start_check(1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int row = 0; row < 4; row++) begin
        if (f == 1 && row == 2) enable = 1'b0;
        for (int p = 5; p >= 0; p--) do_plane(row, p);
      end
      chk("frame_done_count", 32'(nfd), 32'(f + 1));
    end
    chk("frame_period", 32'(period), 2856);
    r0 = nre;
    repeat (20) @(negedge clk);
    chk("stopped_no_re", 32'(nre - r0), 0);
    chk("stopped_oe_n", 32'(oe_n), 1);
    chk("stopped_no_frame_done", 32'(nfd), 2);
    enable = 1'b1;
    start_check(1'b0);
    do_plane(0, 5);
    n = 0;
    while (oe_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_display", 32'(oe_n), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_oe_n", 32'(oe_n), 1);
    chk("async_outs", 32'({raddr, re, row_a, sclk, lat, frame_done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_check(1'b0);
    do_plane(0, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
